// File: rtl/subtractor_pkg.sv
// -----------------------------------------------------------------------------
// subtractor_pkg
// Shared definitions for the bit-serial subtractor slice.
//   SUB_DEFAULT_N : default operand/result width
//   state_t       : FSM state encoding (IDLE / RUN / DONE)
// No ports.
// -----------------------------------------------------------------------------
package subtractor_pkg;

    localparam int SUB_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor_serial_nbit_if.sv
// -----------------------------------------------------------------------------
// subtractor_serial_nbit_if
// Operand/result bundle for subtractor_serial_nbit.
//   in_valid/in_ready   : operand handshake (A, B, borrow_in)
//   out_valid/out_ready : result handshake (diff, borrow_out[, overflow])
//   overflow            : exists only when SUB_OVERFLOW_EN is defined
// Modports: master = operand producer / result consumer, slave = subtractor.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its payload while valid is high and ready is
// low; ready never depends combinationally on valid. A, B and borrow_in are
// only sampled on the operand transfer edge.
// -----------------------------------------------------------------------------
interface subtractor_serial_nbit_if #(
    parameter int N = subtractor_pkg::SUB_DEFAULT_N
);
    logic         in_valid;
    logic         in_ready;
    logic         borrow_in;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;

    modport master (
        output in_valid, borrow_in, A, B, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );
    modport slave (
        input  in_valid, borrow_in, A, B, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );
`else
    modport master (
        output in_valid, borrow_in, A, B, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );
    modport slave (
        input  in_valid, borrow_in, A, B, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
`endif

endinterface

// File: rtl/full_subtractor_1bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_1bit
// Combinational one-bit full subtractor: a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d         : difference bit
//   bout      : borrow out
// -----------------------------------------------------------------------------
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_serial_nbit.sv
// -----------------------------------------------------------------------------
// subtractor_serial_nbit
// Bit-serial ripple-borrow subtractor: diff = A - B - borrow_in (mod 2^N),
// one bit per clock, LSB first, using a single full_subtractor_1bit cell.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : subtractor_serial_nbit_if.slave (operand and result handshakes)
//   dbg_state : current FSM state
// Optional feature macro: SUB_OVERFLOW_EN adds the signed overflow output.
// Latency: out_valid is visible N cycles after the accepting edge; one
// operation per N+2 cycles back to back.
// -----------------------------------------------------------------------------
module subtractor_serial_nbit
    import subtractor_pkg::*;
#(
    parameter int N = SUB_DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    rst,
    subtractor_serial_nbit_if.slave bus,
    output state_t                  dbg_state
);

    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-1:0]    diff_q;
    logic [N-1:0]    diff_next;
    logic            br_q;
    logic [CW-1:0]   cnt_q;
    logic            cell_d;
    logic            cell_bout;
    logic            accept;

    assign accept = (state_q == IDLE) && bus.in_valid;

    full_subtractor_1bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits enter at the MSB so after N shifts bit 0 lands at diff[0].
    if (N == 1) begin : g_diff_one
        assign diff_next = cell_d;
    end else begin : g_diff_many
        assign diff_next = {cell_d, diff_q[N-1:1]};
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)     state_d = RUN;
            RUN:     if (cnt_q == LAST)    state_d = DONE;
            DONE:    if (bus.out_ready)    state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            br_q   <= bus.borrow_in;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            diff_q <= diff_next;
            br_q   <= cell_bout;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------ outputs
    // in_ready is forced low during reset so no operand is taken on that edge.
    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = br_q;
    assign dbg_state      = state_q;

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_msb_q <= bus.A[N-1];
            b_msb_q <= bus.B[N-1];
        end
    end

    // Signed overflow: operands of opposite sign and a result whose sign
    // differs from the minuend's. Gated so it reads 0 outside DONE.
    assign bus.overflow = (state_q == DONE) & (a_msb_q ^ b_msb_q)
                        & (diff_q[N-1] ^ a_msb_q);
`endif

endmodule

// File: tb/tb_subtractor_serial_nbit.sv
// -----------------------------------------------------------------------------
// tb_subtractor_serial_nbit
// Self-checking bench for subtractor_serial_nbit (N = 8). Define
// SUB_OVERFLOW_EN on both RTL and bench to cover the overflow output.
// -----------------------------------------------------------------------------
module tb_subtractor_serial_nbit;
    import subtractor_pkg::*;

    localparam int N  = 8;
    localparam int EW = N + 2;   // {overflow, borrow_out, diff}

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    subtractor_serial_nbit_if #(.N(N)) bus ();

    subtractor_serial_nbit #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ checks
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not seen / not expected at %0t", name, $time);
    endtask

    // ---------------------------------------------------- reference model
    // Plain integer arithmetic: unsigned difference for diff/borrow, signed
    // difference range test for overflow.
    function automatic logic [EW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic bin);
        longint ua, ub, sa, sb, ures, sres, lim;
        logic [N-1:0] d;
        logic bo, ov;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ures = ua - ub - longint'(bin);
        d    = ures[N-1:0];
        bo   = (ures < 0);
        sres = sa - sb - longint'(bin);
        lim  = longint'(1) <<< (N - 1);
        ov   = (sres < -lim) || (sres > lim - 1);
        return {ov, bo, d};
    endfunction

    // --------------------------------------------------------- scoreboard
    logic [EW-1:0] exp_q[$];
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.borrow_in));
                acc_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("spurious_out_valid");
                end else begin
                    e = exp_q[0];
                    check("diff", bus.diff, e[N-1:0]);
                    check("borrow_out", bus.borrow_out, e[N]);
`ifdef SUB_OVERFLOW_EN
                    check("overflow", bus.overflow, e[N+1]);
`endif
                end
                check("in_ready_in_done", bus.in_ready, 0);
                if (!prev_ov) check("latency", cyc - acc_cyc, N);
            end
`ifdef SUB_OVERFLOW_EN
            else begin
                check("overflow_idle", bus.overflow, 0);
            end
`endif
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // ----------------------------------------------------- driver tasks
    // All tasks start and end on a falling edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        int t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail("send_timeout");
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.borrow_in = bin;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.A         = N'($urandom);
        bus.B         = N'($urandom);
        bus.borrow_in = 1'($urandom);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail("out_valid_timeout");
    endtask

    task automatic receive(input int delay);
        wait_valid();
        repeat (delay) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                                input logic [N-1:0] exp_d, input logic exp_b, input logic exp_o);
        check("model_pin", model(a, b, bin), {exp_o, exp_b, exp_d});
        send(a, b, bin);
        wait_valid();
        check("dir_diff", bus.diff, exp_d);
        check("dir_borrow", bus.borrow_out, exp_b);
`ifdef SUB_OVERFLOW_EN
        check("dir_overflow", bus.overflow, exp_o);
`endif
        receive(0);
    endtask

    // ------------------------------------------------------------- main
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.borrow_in = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("in_ready_in_reset", bus.in_ready, 0);
        end
        rst = 1'b0;
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow_out, 0);
        @(negedge clk);

        // Directed vectors with hand-computed results.
        run_directed(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_directed(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_directed(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Backpressure: result held while in_valid is ignored.
        send(8'h12, 8'h34, 1'b0);
        wait_valid();
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.A        = 8'hFF;
            bus.B        = N'($urandom);
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_diff", bus.diff, 8'hDE);
            check("bp_state", dbg_state, DONE);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_back_idle", bus.in_ready, 1);
        run_directed(8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0);

        // Reset on the third RUN edge abandons the operation.
        send(8'h55, 8'h22, 1'b0);
        check("run_state", dbg_state, RUN);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", dbg_state, IDLE);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", bus.in_ready, 1);
        repeat (12) @(negedge clk);
        check("abort_no_result", bus.out_valid, 0);
        run_directed(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

        // Randomized operations with random gaps and consumer delays.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(N'($urandom), N'($urandom), 1'($urandom));
            receive($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/subtractor_serial_nbit.md
# subtractor_serial_nbit

Bit-serial N-bit ripple-borrow subtractor computing `A - B - borrow_in`, one bit per clock, LSB first. It is the inverse-operation counterpart of the team's parallel ripple-carry adder. It trades latency for a single full-subtractor cell and sits behind a valid/ready handshake, so it drops into datapaths where area matters more than throughput.

## Interface
- `N`, default 8: operand and result width in bits. Legal range is N ≥ 1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept operands.
- `borrow_in`  in  1  initial borrow.
- `A`  in  N  minuend.
- `B`  in  N  subtrahend.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  N  `A - B - borrow_in` modulo 2^N.
- `borrow_out`  out  1  final borrow; 1 iff `A < B + borrow_in`, operands taken as unsigned.
- `overflow`  out  1  signed overflow. Present only with `SUB_OVERFLOW_EN`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` = 1: capture `A`, `B` and `borrow_in` into shift registers and internal borrow. Clear the bit counter. Go to RUN.
- **RUN**
  - Each edge processes bit 0 of the shift registers:
    - d = a ^ b ^ br
    - br' = (~a & b) | (~(a ^ b) & br)
  - Shift A and B right. Shift d into the MSB of the diff register.
  - Increment the counter.
  - On the edge that processes bit N-1, go to DONE.
- **DONE**
  - `out_valid` = 1. `diff` and `borrow_out` hold their final values.
  - Outputs stay stable while `out_ready` = 0.
  - On `out_ready` = 1: go to IDLE.
- **Handshake rules**
  - `in_ready` is high only in IDLE and is low while `rst` = 1.
  - `in_valid` is ignored in RUN and DONE, and no operand is queued.
  - `A`, `B` and `borrow_in` are don't-care outside the accepting cycle.
- **Counter:** width is clog2(N+1). It wraps never, because the FSM leaves RUN at count N-1.
- **Edge cases**
  - N = 1: RUN lasts exactly one edge.
  - `diff`/`borrow_out` outside DONE: they show the working registers and are not meaningful.
- **Reset**
  - State goes to IDLE.
  - Zeroed: diff register, borrow, counter, `out_valid`, `overflow`.
  - Reset during RUN or DONE abandons the operation. No `out_valid` is produced for it.

## Timing
- **Accepting edge:** the edge where IDLE and `in_valid` are both high.
- **Latency:** `out_valid` rises after the Nth edge following the accepting edge, i.e. it is visible N cycles after acceptance.
- **Return to IDLE:** the result handshake completes on the edge where DONE and `out_ready` are both high. IDLE, and `in_ready` = 1, follow that edge.
- **Back-to-back throughput:** one operation per N+2 cycles.
- **Outputs:** `in_ready` and `out_valid` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - Captures `A[N-1]` and `B[N-1]` at acceptance.
  - `overflow` = (a_msb ≠ b_msb) & (diff[N-1] ≠ a_msb).
  - `overflow` is valid in DONE and is 0 in other states.
- `SUB_OVERFLOW_EN` not defined: the `overflow` port and its registers do not exist.

## Structure
- **Package `subtractor_pkg`:**
  - FSM state enum typedef (IDLE/RUN/DONE).
  - Default width constant.
- **Sub-module `full_subtractor_1bit`:**
  - Combinational; inputs a, b, bin; outputs d, bout.
  - Instantiated once as the serial bit cell.

## Test plan
- N=8, A=0x5A, B=0x3C, `borrow_in`=0 → `diff`=0x1E, `borrow_out`=0. `out_valid` rises 8 cycles after acceptance.
- A=0x00, B=0x01, `borrow_in`=0 → `diff`=0xFF, `borrow_out`=1.
- A=0x10, B=0x10, `borrow_in`=1 → `diff`=0xFF, `borrow_out`=1.
- With `SUB_OVERFLOW_EN`: A=0x80, B=0x01 → `diff`=0x7F, `borrow_out`=0, `overflow`=1. A=0x05, B=0x03 → `overflow`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE, and drive `in_valid`=1 with A=0xFF.
  - Expected: `diff` is stable and `in_ready`=0 throughout.
  - After `out_ready`=1, the next accepted operation computes correctly.
- Reset asserted on the 3rd RUN edge → IDLE on the next edge, and `out_valid` never asserts. A subsequent A=0x03, B=0x05 gives `diff`=0xFE, `borrow_out`=1.
